// File: rtl/tdc_ctrl_pkg.sv
// tdc_ctrl_pkg: state encoding and default timing constants shared by the
// TDC measurement controller and its timer.
package tdc_ctrl_pkg;
    localparam int SETTLE_CYC_DEF  = 5;
    localparam int TIMEOUT_CYC_DEF = 8192;
    localparam int TW_DEF          = 14;

    typedef enum logic [2:0] {
        IDLE,
        ARM_START,
        SETTLE_START,
        TRIG_START,
        ARM_STOP,
        SETTLE_STOP,
        TRIG_STOP,
        WAIT_DONE
    } state_t;
endpackage

// File: rtl/tdc_ctrl_timer.sv
// tdc_ctrl_timer: up-counter with synchronous clear and terminal-count compare,
// reused for both settle delays and wait-state timeouts.
module tdc_ctrl_timer
    import tdc_ctrl_pkg::*;
#(
    parameter int TW = TW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic [TW-1:0] i_tc,
    output logic          o_hit
);
    logic [TW-1:0] r_count;

    always_ff @(posedge clk or posedge reset)
        if (reset) r_count <= '0;
        else       r_count <= i_clr ? '0 : r_count + 1'b1;

    assign o_hit = r_count == i_tc;
endmodule

// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl: sequences one start/stop TDC measurement, strobes the data
// handler after each conversion settles and captures the measured interval.
module tdc_meas_ctrl
    import tdc_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int TW          = TW_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        abort,
    input  logic        tdc_stop,
    input  logic        dh_done,
    input  logic [63:0] dh_timedata,
    output logic        start_en,
    output logic        stop_en,
    output logic        alu_triger,
    output logic        busy,
    output logic [63:0] result,
    output logic        result_valid,
    output logic        timeout_err
);
    state_t        r_state, w_next;
    logic          r_stop_prev, r_start_en, r_stop_en, r_alu_triger, r_busy, r_result_valid, r_timeout_err;
    logic [63:0]   r_result;
    logic          w_rise, w_hit, w_clr, w_capture, w_timeout;
    logic [TW-1:0] w_tc;

    assign w_rise = tdc_stop & ~r_stop_prev;
    assign w_tc   = (r_state == SETTLE_START || r_state == SETTLE_STOP) ? TW'(SETTLE_CYC - 1) : TW'(TIMEOUT_CYC - 1);
    // Timer restarts on every state entry and is held at zero while idle
    assign w_clr  = (w_next != r_state) || (r_state == IDLE);

    tdc_ctrl_timer #(.TW(TW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_clr),
        .i_tc  (w_tc),
        .o_hit (w_hit)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_state     <= IDLE;
            r_stop_prev <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_stop_prev <= tdc_stop;
        end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        if (abort) w_next = IDLE;
        else case (r_state)
            IDLE:         w_next = req ? ARM_START : IDLE;
            ARM_START: begin
                w_next    = w_rise ? SETTLE_START : w_hit ? IDLE : ARM_START;
                w_timeout = !w_rise && w_hit;
            end
            SETTLE_START: w_next = w_hit ? TRIG_START : SETTLE_START;
            TRIG_START:   w_next = ARM_STOP;
            ARM_STOP: begin
                w_next    = w_rise ? SETTLE_STOP : w_hit ? IDLE : ARM_STOP;
                w_timeout = !w_rise && w_hit;
            end
            SETTLE_STOP:  w_next = w_hit ? TRIG_STOP : SETTLE_STOP;
            TRIG_STOP:    w_next = WAIT_DONE;
            WAIT_DONE: begin
                w_next    = (dh_done || w_hit) ? IDLE : WAIT_DONE;
                w_capture = dh_done;
                w_timeout = !dh_done && w_hit;
            end
            default:      w_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with r_state
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_start_en     <= 1'b0;
            r_stop_en      <= 1'b0;
            r_alu_triger   <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_result       <= 64'd0;
        end else begin
            r_start_en     <= w_next == ARM_START;
            r_stop_en      <= w_next == ARM_STOP;
            r_alu_triger   <= w_next == TRIG_START || w_next == TRIG_STOP;
            r_busy         <= w_next != IDLE;
            r_result_valid <= w_capture;
            r_timeout_err  <= w_timeout;
            if (w_capture) r_result <= dh_timedata;
        end

    assign start_en     = r_start_en;
    assign stop_en      = r_stop_en;
    assign alu_triger   = r_alu_triger;
    assign busy         = r_busy;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign timeout_err  = r_timeout_err;
endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// tb_tdc_meas_ctrl: table-driven measurements plus corner-case sequences; "cycle c"
// is the value present at rising edge c counted from each sequence's base.
module tb_tdc_meas_ctrl;
    import tdc_ctrl_pkg::*;

    localparam int SC = SETTLE_CYC_DEF;

    typedef struct { int s1; int s2; int dn; logic [63:0] d; } vec_t;
    typedef struct { int c; logic [63:0] d; } exp_t;

    logic        clk = 1'b0, reset = 1'b1, req = 1'b0, abort = 1'b0, tdc_stop = 1'b0, dh_done = 1'b0;
    logic [63:0] dh_timedata = '0;
    logic        a_start_en, a_stop_en, a_alu_triger, a_busy, a_result_valid, a_timeout_err;
    logic        b_start_en, b_stop_en, b_alu_triger, b_busy, b_result_valid, b_timeout_err;
    logic [63:0] a_result, b_result;
    int          cyc = 0, base = 0, total = 0, bad = 0, b_valid = 0, bv0;
    exp_t        sb[$];
    exp_t        e;
    int          alu_log[$];
    int          to_log[$];
    vec_t        vecs[4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tdc_meas_ctrl u_a (
        .clk(clk), .reset(reset), .req(req), .abort(abort), .tdc_stop(tdc_stop),
        .dh_done(dh_done), .dh_timedata(dh_timedata), .start_en(a_start_en), .stop_en(a_stop_en),
        .alu_triger(a_alu_triger), .busy(a_busy), .result(a_result),
        .result_valid(a_result_valid), .timeout_err(a_timeout_err)
    );

    tdc_meas_ctrl #(.TIMEOUT_CYC(100)) u_b (
        .clk(clk), .reset(reset), .req(req), .abort(abort), .tdc_stop(tdc_stop),
        .dh_done(dh_done), .dh_timedata(dh_timedata), .start_en(b_start_en), .stop_en(b_stop_en),
        .alu_triger(b_alu_triger), .busy(b_busy), .result(b_result),
        .result_valid(b_result_valid), .timeout_err(b_timeout_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic at(input int c);
        while (cyc < base + c - 1) @(negedge clk);
    endtask

    task automatic reset_all;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic stop_pulse(input int c);
        at(c);
        tdc_stop = 1'b1;
        at(c + 2);
        tdc_stop = 1'b0;
    endtask

    task automatic req_pulse(input int c);
        at(c);
        req = 1'b1;
        at(c + 1);
        req = 1'b0;
    endtask

    task automatic abort_pulse(input int c);
        at(c);
        abort = 1'b1;
        at(c + 1);
        abort = 1'b0;
    endtask

    task automatic done_pulse(input int c, input logic [63:0] d, input bit expect_valid);
        at(c);
        dh_done = 1'b1;
        dh_timedata = d;
        if (expect_valid) sb.push_back('{c + 1, d});
        at(c + 1);
        dh_done = 1'b0;
    endtask

    task automatic measure(input int s1, input int s2, input int dn, input logic [63:0] d);
        base = cyc;
        req_pulse(1);
        stop_pulse(s1);
        stop_pulse(s2);
        done_pulse(dn, d, 1'b1);
        at(dn + 4);
        chk("vec_alu_count", alu_log.size(), 2);
        chk("vec_alu_first", alu_log[0], s1 + SC + 1);
        chk("vec_alu_second", alu_log[1], s2 + SC + 1);
        chk("vec_busy_after", a_busy, 1'b0);
        chk("vec_result_hold", a_result, d);
        alu_log.delete();
    endtask

    // Scoreboard side: log strobes and pop expected results as result_valid appears
    always @(negedge clk) begin
        if (a_alu_triger) alu_log.push_back(cyc + 1 - base);
        if (b_timeout_err) to_log.push_back(cyc + 1 - base);
        if (b_result_valid) b_valid++;
        chk("a_no_timeout", a_timeout_err, 1'b0);
        if (a_result_valid) begin
            if (sb.size() == 0) chk("unexpected_valid", a_result_valid, 1'b0);
            else begin
                e = sb.pop_front();
                chk("valid_cycle", cyc + 1 - base, e.c);
                chk("result", a_result, e.d);
            end
        end
    end

    initial begin
        vecs = '{'{10, 300, 320, 64'h1203},
                 '{3, 12, 19, 64'hFFFF_FFFF_FFFF_FFFF},
                 '{5, 40, 47, 64'h0},
                 '{2, 9, 30, 64'hDEAD_BEEF_0123_4567}};
        @(negedge clk);
        chk("rst_flags", {a_start_en, a_stop_en, a_alu_triger, a_busy, a_result_valid, a_timeout_err}, 6'b0);
        chk("rst_result", a_result, 64'd0);
        reset_all();
        for (int i = 0; i < 4; i++) measure(vecs[i].s1, vecs[i].s2, vecs[i].dn, vecs[i].d);

        // tdc_stop already high when ARM_START is entered
        base = cyc;
        at(1);
        tdc_stop = 1'b1;
        req_pulse(2);
        at(20);
        chk("stale_still_armed", a_start_en, 1'b1);
        chk("stale_no_alu", alu_log.size(), 0);
        at(21);
        tdc_stop = 1'b0;
        stop_pulse(24);
        at(32);
        chk("stale_alu_count", alu_log.size(), 1);
        chk("stale_alu_cycle", alu_log[0], 24 + SC + 1);
        chk("stale_stop_en", a_stop_en, 1'b1);
        abort_pulse(33);
        at(35);
        chk("stale_abort_idle", a_busy, 1'b0);
        alu_log.delete();

        // req with abort in IDLE, then abort during SETTLE_STOP
        base = cyc;
        at(1);
        req = 1'b1;
        abort = 1'b1;
        at(2);
        req = 1'b0;
        abort = 1'b0;
        at(3);
        chk("req_abort_idle", a_busy, 1'b0);
        req_pulse(4);
        stop_pulse(6);
        stop_pulse(15);
        abort_pulse(17);
        at(18);
        chk("abort_busy", a_busy, 1'b0);
        chk("abort_stop_en", a_stop_en, 1'b0);
        at(25);
        chk("abort_alu_count", alu_log.size(), 1);
        chk("abort_alu_cycle", alu_log[0], 6 + SC + 1);
        alu_log.delete();

        // second req while busy and dh_done outside WAIT_DONE are ignored
        base = cyc;
        done_pulse(1, 64'hAA, 1'b0);
        req_pulse(2);
        req_pulse(5);
        stop_pulse(6);
        done_pulse(15, 64'hBB, 1'b0);
        stop_pulse(20);
        req_pulse(28);
        done_pulse(35, 64'h3344, 1'b1);
        done_pulse(40, 64'h99, 1'b0);
        at(45);
        chk("ignore_alu_count", alu_log.size(), 2);
        chk("ignore_alu_second", alu_log[1], 20 + SC + 1);
        chk("ignore_busy", a_busy, 1'b0);
        chk("ignore_result", a_result, 64'h3344);
        alu_log.delete();

        // timeout in ARM_STOP on the short-timeout instance, then event beating timeout
        reset_all();
        to_log.delete();
        bv0 = b_valid;
        base = cyc;
        req_pulse(1);
        stop_pulse(3);
        stop_pulse(12);
        done_pulse(20, 64'h55, 1'b1);
        req_pulse(30);
        stop_pulse(32);
        at(138);
        chk("to_busy_before", b_busy, 1'b1);
        at(139);
        chk("to_busy_after", b_busy, 1'b0);
        at(142);
        chk("to_count", to_log.size(), 1);
        chk("to_cycle", to_log[0], 139);
        chk("to_result_kept", b_result, 64'h55);
        chk("to_valid_count", b_valid - bv0, 1);
        abort_pulse(143);
        req_pulse(145);
        stop_pulse(147);
        stop_pulse(253);
        at(256);
        chk("race_no_timeout", to_log.size(), 1);
        chk("race_busy", b_busy, 1'b1);
        abort_pulse(257);
        at(259);
        chk("race_abort_idle", b_busy, 1'b0);
        alu_log.delete();

        // asynchronous reset while waiting for dh_done
        reset_all();
        base = cyc;
        req_pulse(1);
        stop_pulse(3);
        stop_pulse(12);
        at(25);
        chk("wait_busy", a_busy, 1'b1);
        #2 reset = 1'b1;
        #1 chk("async_rst_flags", {a_start_en, a_stop_en, a_alu_triger, a_busy, a_result_valid, a_timeout_err}, 6'b0);
        chk("async_rst_result", a_result, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        done_pulse(28, 64'h77, 1'b0);
        at(35);
        chk("post_rst_busy", a_busy, 1'b0);
        chk("post_rst_result", a_result, 64'd0);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
